a2d_sched: RTL
==============

A2D_SCHED -- requirements
Module: a2d_sched

Interface -- parameters
REQ-001 SHALL have parameter GAP_CYC, default 2: idle cycles inserted between consecutive SPI transactions (1..15).

Interface -- ports
REQ-002 SHALL have port clk  input  1  50MHz system clock; the block uses only this clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port nxt  input  1  single-cycle request to start one conversion round.
REQ-005 SHALL have port spi_done  input  1  single-cycle pulse from the SPI master marking transaction complete.
REQ-006 SHALL have port spi_rd_data  input  16  data returned by the SPI master; valid in the spi_done cycle.
REQ-007 SHALL have port spi_wrt  output  1  single-cycle pulse that starts an SPI transaction.
REQ-008 SHALL have port spi_cmd  output  16  command word for the SPI master; stable from the spi_wrt cycle until spi_done.
REQ-009 SHALL have port lft_ld  output  12  latest left load-cell result.
REQ-010 SHALL have port rght_ld  output  12  latest right load-cell result.
REQ-011 SHALL have port steer_pot  output  12  latest steering-pot result.
REQ-012 SHALL have port batt  output  12  latest battery result.
REQ-013 SHALL have port busy  output  1  high while a round is in progress.
REQ-014 SHALL have port vld  output  1  single-cycle pulse when a round completes.

Function
REQ-015 A round SHALL convert these channels in fixed order: lft_ld on ch0, rght_ld on ch4, steer_pot on ch5, batt on ch6.
REQ-016 spi_cmd SHALL be {2'b00, ch[2:0], 11'h000} for both transactions of a channel.
REQ-017 Each channel SHALL use two transactions:
  - first: selects the channel; its spi_rd_data is discarded;
  - second: spi_rd_data[11:0] is the result for that channel.
REQ-018 The state machine SHALL have states IDLE, SEND1, WAIT1, GAP, SEND2, WAIT2, GAP2.
REQ-019 IDLE -> SEND1 SHALL occur on nxt; channel index is cleared to 0.
REQ-020 SEND1 and SEND2 SHALL each assert spi_wrt for exactly one cycle, then move to WAIT1 and WAIT2 respectively.
REQ-021 WAIT1 SHALL go to GAP on spi_done.
REQ-022 GAP SHALL count GAP_CYC cycles, then go to SEND2.
REQ-023 WAIT2 on spi_done SHALL:
  - capture spi_rd_data[11:0] into the current channel's output register in that same clock edge;
  - go to GAP2.
REQ-024 GAP2 SHALL count GAP_CYC cycles, then:
  - if the channel was the last: go to IDLE and pulse vld for one cycle;
  - otherwise: increment the channel index and go to SEND1.
REQ-025 vld SHALL rise the cycle after the last GAP2 count expires.
REQ-026 Minimum latency from nxt to vld SHALL be 4*(2*(1+1+GAP_CYC)) cycles plus SPI transaction time.
REQ-027 busy SHALL be high in every state except IDLE, including the vld cycle's predecessor GAP2.
REQ-028 nxt received while busy SHALL be ignored; it is neither queued nor restarts the round.
REQ-029 nxt in the same cycle as the round-ending GAP2 expiry SHALL be ignored.
REQ-030 spi_done outside WAIT1/WAIT2 SHALL be ignored, with no state or register change.
REQ-031 Result registers SHALL only change on the capturing spi_done edge.
REQ-032 Untouched channels SHALL hold their previous values.
REQ-033 The GAP counter SHALL be 4 bits, clear on entry to GAP/GAP2, and SHALL not wrap.

Reset
REQ-034 On rst_n low, asynchronously:
  - state = IDLE and channel index = 0;
  - lft_ld = rght_ld = steer_pot = batt = 12'h000;
  - spi_wrt = 0, busy = 0, vld = 0;
  - spi_cmd = 16'h0000.
REQ-035 Reset mid-round SHALL abandon the round with no vld pulse.
REQ-036 A spi_done arriving after reset release SHALL be ignored.

Verification
REQ-037 Reset, then nxt, with the SPI model returning 16'hF123/16'h0ABC per channel -> cmds 0000,0000,2000,2000,2800,2800,3000,3000; all four outputs = 12'hABC; one vld pulse; busy falls with vld.
REQ-038 Second-transaction data 16'h5FFF on ch4 -> rght_ld = 12'hFFF; upper nibble dropped; other channels unchanged.
REQ-039 nxt pulsed three times during a round -> exactly 8 spi_wrt pulses and one vld.
REQ-040 Spurious spi_done in IDLE and in GAP -> no state change, no register update.
REQ-041 rst_n asserted during WAIT2 of ch5, then nxt -> outputs 0 after reset; new round starts at ch0; no vld before it completes.
REQ-042 GAP_CYC=1 and GAP_CYC=15 -> spi_wrt spacing after spi_done = GAP_CYC+1 cycles.

Source files
------------

// File: rtl/a2d_sched.sv
// a2d_sched -- conversion-round scheduler for an SPI-attached A2D converter.
//
// On a single-cycle nxt request it walks four channels in fixed order
// (ch0 -> lft_ld, ch4 -> rght_ld, ch5 -> steer_pot, ch6 -> batt). Each channel
// takes two SPI transactions. The first selects the channel, and its returned
// data is discarded. The second returns the conversion result in
// spi_rd_data[11:0]. GAP_CYC idle cycles separate consecutive transactions.
//
// Ports:
//   clk          in   system clock (only clock used)
//   rst_n        in   asynchronous active-low reset
//   nxt          in   single-cycle request to start a round (ignored while busy)
//   spi_done     in   single-cycle pulse: SPI transaction complete
//   spi_rd_data  in   16-bit SPI read data, valid with spi_done
//   spi_wrt      out  single-cycle pulse starting an SPI transaction
//   spi_cmd      out  16-bit command word {2'b00, ch[2:0], 11'h000}
//   lft_ld       out  latest ch0 result
//   rght_ld      out  latest ch4 result
//   steer_pot    out  latest ch5 result
//   batt         out  latest ch6 result
//   busy         out  high whenever the scheduler is not idle
//   vld          out  single-cycle pulse when a round completes
module a2d_sched #(
    parameter int GAP_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        spi_done,
    input  logic [15:0] spi_rd_data,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        busy,
    output logic        vld
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SEND1 = 3'd1;
    localparam logic [2:0] WAIT1 = 3'd2;
    localparam logic [2:0] GAP   = 3'd3;
    localparam logic [2:0] SEND2 = 3'd4;
    localparam logic [2:0] WAIT2 = 3'd5;
    localparam logic [2:0] GAP2  = 3'd6;

    // Terminal count of the gap counter: GAP_CYC cycles are 0..GAP_CYC-1.
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

    logic [2:0]  state_q, state_d;
    logic [1:0]  chan_q, chan_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] lft_q, lft_d;
    logic [11:0] rght_q, rght_d;
    logic [11:0] steer_q, steer_d;
    logic [11:0] batt_q, batt_d;
    logic        vld_q, vld_d;
    logic        gap_done;
    logic [2:0]  ch_sel;

    // Only the low 12 bits of the read data carry a result.
    logic        rd_hi_unused;
    assign rd_hi_unused = ^spi_rd_data[15:12];

    assign gap_done = (cnt_q == GAP_LAST);

    // Channel index -> physical A2D channel number.
    always_comb begin
        ch_sel = 3'd0;
        case (chan_q)
            2'd0:    ch_sel = 3'd0;
            2'd1:    ch_sel = 3'd4;
            2'd2:    ch_sel = 3'd5;
            default: ch_sel = 3'd6;
        endcase
    end

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        cnt_d   = cnt_q;
        lft_d   = lft_q;
        rght_d  = rght_q;
        steer_d = steer_q;
        batt_d  = batt_q;
        vld_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (nxt) begin
                    state_d = SEND1;
                    chan_d  = 2'd0;
                end
            end
            SEND1: state_d = WAIT1;
            WAIT1: begin
                if (spi_done) begin
                    state_d = GAP;
                    cnt_d   = 4'd0;
                end
            end
            GAP: begin
                if (gap_done) begin
                    state_d = SEND2;
                end else if (cnt_q != 4'hF) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SEND2: state_d = WAIT2;
            WAIT2: begin
                if (spi_done) begin
                    state_d = GAP2;
                    cnt_d   = 4'd0;
                    case (chan_q)
                        2'd0:    lft_d   = spi_rd_data[11:0];
                        2'd1:    rght_d  = spi_rd_data[11:0];
                        2'd2:    steer_d = spi_rd_data[11:0];
                        default: batt_d  = spi_rd_data[11:0];
                    endcase
                end
            end
            GAP2: begin
                if (gap_done) begin
                    if (chan_q == 2'd3) begin
                        state_d = IDLE;
                        vld_d   = 1'b1;
                    end else begin
                        state_d = SEND1;
                        chan_d  = chan_q + 2'd1;
                    end
                end else if (cnt_q != 4'hF) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            chan_q  <= 2'd0;
            cnt_q   <= 4'd0;
            lft_q   <= 12'h000;
            rght_q  <= 12'h000;
            steer_q <= 12'h000;
            batt_q  <= 12'h000;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            cnt_q   <= cnt_d;
            lft_q   <= lft_d;
            rght_q  <= rght_d;
            steer_q <= steer_d;
            batt_q  <= batt_d;
            vld_q   <= vld_d;
        end
    end

    // The command follows the channel index, which only changes when entering
    // SEND1. It is therefore stable across both transactions of a channel, and
    // reset clears it to 16'h0000.
    assign spi_cmd   = {2'b00, ch_sel, 11'h000};
    assign spi_wrt   = (state_q == SEND1) || (state_q == SEND2);
    assign busy      = (state_q != IDLE);
    assign vld       = vld_q;
    assign lft_ld    = lft_q;
    assign rght_ld   = rght_q;
    assign steer_pot = steer_q;
    assign batt      = batt_q;

endmodule
